// File: rtl/box_pkg.sv
// Purpose: shared types, 18-entry RGB444 palette ROM and index clamp for the box renderer.
// Latency: none (declarations only).
// Backpressure: none; no ports.
package box_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [4:0]  pal_idx_t;

  localparam int       PALETTE_SIZE = 18;
  localparam pal_idx_t IDX_MAX      = pal_idx_t'(PALETTE_SIZE - 1);

  localparam rgb444_t PALETTE [PALETTE_SIZE] = '{
    12'hF80,  // 0  orange
    12'h0AF,  // 1  sky blue
    12'hF00,  // 2  red
    12'h0F0,  // 3  green
    12'h00F,  // 4  blue
    12'hFF0,  // 5  yellow
    12'h0FF,  // 6  cyan
    12'hF0F,  // 7  magenta
    12'h888,  // 8  mid grey
    12'h444,  // 9  dark grey
    12'hC40,  // 10 rust
    12'h4C0,  // 11 lime
    12'h04C,  // 12 navy
    12'hA5F,  // 13 violet
    12'h5FA,  // 14 mint
    12'hFA5,  // 15 peach
    12'h222,  // 16 near black
    12'hFFF   // 17 white
  };

  // Indices beyond the ROM fold to entry 0 rather than reading garbage.
  function automatic pal_idx_t clamp_idx(input pal_idx_t idx);
    return (idx > IDX_MAX) ? '0 : idx;
  endfunction

endpackage

// File: rtl/box_color_render_if.sv
// Purpose: per-box colour bundle between the renderer top and one fade channel.
// Latency: none (wires only); rgb is the blend of the stage-1 registered palette reads.
// Backpressure: none; frame_start/color_index are sampled unconditionally.
// Ports: frame_start, color_index (master->slave); rgb, busy (slave->master).
interface box_color_render_if;
  import box_pkg::*;

  logic     frame_start;
  pal_idx_t color_index;
  rgb444_t  rgb;
  logic     busy;

  modport master (output frame_start, color_index, input rgb, busy);
  modport slave  (input frame_start, color_index, output rgb, busy);

endinterface

// File: rtl/box_fade_channel.sv
// Purpose: one box's colour state: frame-start index latch, fade counter and P/T blend.
// Latency: palette reads registered once (stage 1); blend is combinational on those registers.
// Backpressure: none; state only advances on frame_start.
// Ports: clk_machine, rst_machine (async, active-high), bus (slave side of the colour bundle).
module box_fade_channel
  import box_pkg::*;
#(
  parameter int       FADE_FRAMES = 8,
  parameter pal_idx_t RST_IDX     = '0
) (
  input  logic              clk_machine,
  input  logic              rst_machine,
  box_color_render_if.slave bus
);

  localparam int               CNT_W   = $clog2(FADE_FRAMES);
  localparam int               SUM_W   = 4 + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FADE_FRAMES - 1);

  pal_idx_t         prev_q, prev_d;
  pal_idx_t         tgt_q,  tgt_d;
  pal_idx_t         idx_s;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  // Stage-1 copies: palette reads and the weight that goes with them.
  rgb444_t          p_q, t_q;
  logic [CNT_W-1:0] wcnt_q;

  assign idx_s = clamp_idx(bus.color_index);

  // A new index always wins over a decrement, so a change mid-fade restarts
  // from whatever was the target at that moment.
  always_comb begin
    prev_d = prev_q;
    tgt_d  = tgt_q;
    cnt_d  = cnt_q;
    if (bus.frame_start) begin
      if (idx_s != tgt_q) begin
        prev_d = tgt_q;
        tgt_d  = idx_s;
        cnt_d  = CNT_MAX;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Stage 1 reads the current (pre-update) state, so a pixel coinciding
  // with frame_start still renders with the old colours.
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      prev_q <= RST_IDX;
      tgt_q  <= RST_IDX;
      cnt_q  <= '0;
      p_q    <= PALETTE[RST_IDX];
      t_q    <= PALETTE[RST_IDX];
      wcnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      p_q    <= PALETTE[prev_q];
      t_q    <= PALETTE[tgt_q];
      wcnt_q <= cnt_q;
    end
  end

  // (P*cnt + T*(F-cnt)) / F per nibble; F is a power of two so the divide
  // is a shift. Max sum is 15*F, which fits SUM_W bits.
  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [SUM_W-1:0] sum;
    assign sum = SUM_W'(p_q[4*c +: 4]) * SUM_W'(wcnt_q)
               + SUM_W'(t_q[4*c +: 4]) * (SUM_W'(FADE_FRAMES) - SUM_W'(wcnt_q));
    assign bus.rgb[4*c +: 4] = 4'(sum >> CNT_W);
  end

  assign bus.busy = (cnt_q != '0);

endmodule

// File: rtl/box_color_render.sv
// Purpose: two-box RGB444 renderer with per-box palette cross-fade; box 1 wins on overlap.
// Latency: exactly 2 cycles pixel in -> pixel out, one pixel per cycle.
// Backpressure: none; the pixel stream is never stalled.
// Ports: clk_machine/rst_machine; colour indices + frame_start; pixel valid/x/y;
//        box 1/2 origin and size; o_pix_valid, o_rgb, o_fade_busy.
module box_color_render
  import box_pkg::*;
#(
  parameter int      FADE_FRAMES = 8,
  parameter rgb444_t BG_RGB      = 12'h000
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic [4:0]  i_color_index1,
  input  logic [4:0]  i_color_index2,
  input  logic        i_frame_start,
  input  logic        i_pix_valid,
  input  logic [9:0]  i_pix_x,
  input  logic [9:0]  i_pix_y,
  input  logic [9:0]  i_box1_x,
  input  logic [9:0]  i_box1_y,
  input  logic [9:0]  i_box1_w,
  input  logic [9:0]  i_box1_h,
  input  logic [9:0]  i_box2_x,
  input  logic [9:0]  i_box2_y,
  input  logic [9:0]  i_box2_w,
  input  logic [9:0]  i_box2_h,
  output logic        o_pix_valid,
  output logic [11:0] o_rgb,
  output logic        o_fade_busy
);

  box_color_render_if u_box1_if ();
  box_color_render_if u_box2_if ();

  assign u_box1_if.frame_start = i_frame_start;
  assign u_box1_if.color_index = i_color_index1;
  assign u_box2_if.frame_start = i_frame_start;
  assign u_box2_if.color_index = i_color_index2;

  box_fade_channel #(.FADE_FRAMES(FADE_FRAMES), .RST_IDX(IDX_MAX)) u_box1 (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .bus         (u_box1_if)
  );

  box_fade_channel #(.FADE_FRAMES(FADE_FRAMES), .RST_IDX(pal_idx_t'(0))) u_box2 (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .bus         (u_box2_if)
  );

  // End coordinates are formed at 11 bits so a box reaching past 1023
  // still covers the right edge instead of wrapping to a tiny range.
  function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                  input logic [9:0] bx, input logic [9:0] by,
                                  input logic [9:0] bw, input logic [9:0] bh);
    logic [10:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, bx} + {1'b0, bw};
    y_end = {1'b0, by} + {1'b0, bh};
    return (px >= bx) && ({1'b0, px} < x_end) &&
           (py >= by) && ({1'b0, py} < y_end);
  endfunction

  logic    vld1_q, hit1_q, hit2_q;
  logic    hit1_d, hit2_d;
  logic    vld2_q, busy_q;
  rgb444_t rgb_q, rgb_d;

  assign hit1_d = in_box(i_pix_x, i_pix_y, i_box1_x, i_box1_y, i_box1_w, i_box1_h);
  assign hit2_d = in_box(i_pix_x, i_pix_y, i_box2_x, i_box2_y, i_box2_w, i_box2_h);

  // Invalid slots output black so downstream never sees stale colour.
  always_comb begin
    rgb_d = '0;
    if (vld1_q) begin
      if (hit1_q)      rgb_d = u_box1_if.rgb;
      else if (hit2_q) rgb_d = u_box2_if.rgb;
      else             rgb_d = BG_RGB;
    end
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      vld1_q <= 1'b0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      vld2_q <= 1'b0;
      rgb_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld1_q <= i_pix_valid;
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
      vld2_q <= vld1_q;
      rgb_q  <= rgb_d;
      busy_q <= u_box1_if.busy | u_box2_if.busy;
    end
  end

  assign o_pix_valid = vld2_q;
  assign o_rgb       = rgb_q;
  assign o_fade_busy = busy_q;

endmodule
